rv32i_registers: RTL and testbench
==================================

RV32I_REGISTERS -- requirements
Module: rv32i_registers

Interface
REQ-001 Parameter DataWidth, default 32, register and data port width in bits.
REQ-002 Parameter AddrWidth, default 5, register index width; the file holds 2**AddrWidth registers (32).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs1  input  AddrWidth  read port 1 register index.
REQ-006 rs1_data_out  output  DataWidth (signed)  contents of register rs1.
REQ-007 rs2  input  AddrWidth  read port 2 register index.
REQ-008 rs2_data_out  output  DataWidth (signed)  contents of register rs2.
REQ-009 rd  input  AddrWidth  write port register index.
REQ-010 rd_write_enable  input  1  write strobe; active high.
REQ-011 rd_data_in  input  DataWidth  write data.

Function
REQ-012 The block SHALL implement 32 x 32-bit registers x0..x31 with two independent read ports and one write port.
REQ-013 Reads SHALL be combinational: rs1_data_out and rs2_data_out reflect the current stored contents of the indexed registers in the same cycle rs1/rs2 change, with zero clock latency.
REQ-014 Both read ports SHALL index the same or different registers simultaneously without interference.
REQ-015 On a rising clk edge with rd_write_enable=1 and rd!=0, register rd SHALL be loaded with rd_data_in.
REQ-016 With rd_write_enable=0 no register SHALL change.
REQ-017 x0 SHALL always read 0; writes with rd=0 SHALL be ignored.
REQ-018 Read-during-write: in the cycle a write is pending, a read of rd SHALL return the old value; the new value SHALL appear immediately after the write edge (no write-to-read bypass).
REQ-019 A write to rd SHALL NOT disturb any other register.
REQ-020 Write data and indices SHALL be sampled as present just before the rising edge; a rd/rd_data_in change at the same edge as the write SHALL NOT affect that write.
REQ-021 Reads of indices not yet written since reset SHALL return 0.

Reset
REQ-022 While rst_n=0, all registers SHALL asynchronously clear to 0, so both read outputs read 0 for any index.
REQ-023 A write coinciding with an active reset SHALL be discarded.
REQ-024 After rst_n deasserts, writes SHALL take effect from the first rising clk edge.

Structure
REQ-025 DataWidth and AddrWidth defaults and the register count (32) SHALL be defined as constants in a shared package (rv32i_pkg), used by this block and the core.
REQ-026 The block SHALL be a single module with no sub-modules; storage is a register array with per-register clock enable.

Verification
REQ-027 Reset, then read every index on both ports -> all outputs read 0x00000000.
REQ-028 Write x5=0xDEADBEEF (we=1, one edge); set rs1=5, rs2=5 -> both ports read 0xDEADBEEF the cycle after the edge; in the cycle before the edge rs1=5 reads 0.
REQ-029 Write rd=0 with 0x12345678 -> rs1=0 reads 0x00000000.
REQ-030 Write x1=0x1, x31=0xFFFFFFFF; read rs1=1, rs2=31 -> 0x00000001 and 0xFFFFFFFF (signed -1); x2..x30 still 0.
REQ-031 Hold rd=7, rd_data_in=0xAAAA5555 with we=0 for 3 edges -> x7 remains 0; assert we for one edge -> x7 reads 0xAAAA5555.
REQ-032 After writing x3=0x55, pulse rst_n low between clock edges -> x3 reads 0 immediately; a write asserted during reset -> register stays 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants used by the register file and the core.
package rv32i_pkg;

  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned RegCount     = 2 ** RegAddrWidth;

  typedef logic [RegDataWidth-1:0] reg_data_t;
  typedef logic [RegAddrWidth-1:0] reg_addr_t;

endpackage

// File: rtl/rv32i_registers.sv
// RV32I integer register file: two combinational read ports, one synchronous write port.
// x0 is hard-wired to zero; all registers clear asynchronously on reset.
module rv32i_registers
  import rv32i_pkg::*;
#(
  parameter int unsigned DataWidth = RegDataWidth,
  parameter int unsigned AddrWidth = RegAddrWidth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AddrWidth-1:0]        rs1,
  output logic signed [DataWidth-1:0] rs1_data_out,
  input  logic [AddrWidth-1:0]        rs2,
  output logic signed [DataWidth-1:0] rs2_data_out,
  input  logic [AddrWidth-1:0]        rd,
  input  logic                        rd_write_enable,
  input  logic [DataWidth-1:0]        rd_data_in
);

  localparam int unsigned NumRegs = 2 ** AddrWidth;

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];
  logic [NumRegs-1:0]   wr_en;

  // Decode the write port into per-register enables; index 0 never enables.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      wr_en[i]  = rd_write_enable && (i != 0) && (rd == AddrWidth'(i));
      regs_d[i] = wr_en[i] ? rd_data_in : regs_q[i];
    end
  end

  // Storage: one enabled flop bank per register, asynchronously cleared.
  for (genvar g = 0; g < NumRegs; g++) begin : g_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[g] <= '0;
      end else if (wr_en[g]) begin
        regs_q[g] <= regs_d[g];
      end
    end
  end

  // Read ports see stored state only, so a pending write returns the old value.
  always_comb begin
    rs1_data_out = regs_q[rs1];
    rs2_data_out = regs_q[rs2];
  end

endmodule

// File: tb/tb_rv32i_registers.sv
// Directed, table-driven bench for the RV32I register file.
module tb_rv32i_registers;

  logic               clk;
  logic               rst_n;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [4:0]         rd;
  logic               rd_write_enable;
  logic [31:0]        rd_data_in;
  logic signed [31:0] rs1_data_out;
  logic signed [31:0] rs2_data_out;

  int total;
  int bad;

  logic [31:0] mdl [32];

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [11];

  rv32i_registers dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1             (rs1),
    .rs1_data_out    (rs1_data_out),
    .rs2             (rs2),
    .rs2_data_out    (rs2_data_out),
    .rd              (rd),
    .rd_write_enable (rd_write_enable),
    .rd_data_in      (rd_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    // rs1, rs2, we, rd, data, expected rs1 (pre-edge), expected rs2 (pre-edge)
    vecs[0]  = '{5'd5,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1]  = '{5'd5,  5'd5,  1'b1, 5'd0,  32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{5'd0,  5'd5,  1'b1, 5'd1,  32'h00000001, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{5'd1,  5'd0,  1'b1, 5'd31, 32'hFFFFFFFF, 32'h1,        32'h0};
    vecs[4]  = '{5'd1,  5'd31, 1'b0, 5'd7,  32'hAAAA5555, 32'h1,        32'hFFFFFFFF};
    vecs[5]  = '{5'd7,  5'd2,  1'b0, 5'd7,  32'hAAAA5555, 32'h0,        32'h0};
    vecs[6]  = '{5'd7,  5'd30, 1'b0, 5'd7,  32'hAAAA5555, 32'h0,        32'h0};
    vecs[7]  = '{5'd7,  5'd7,  1'b1, 5'd7,  32'hAAAA5555, 32'h0,        32'h0};
    vecs[8]  = '{5'd7,  5'd5,  1'b0, 5'd0,  32'h0,        32'hAAAA5555, 32'hDEADBEEF};
    vecs[9]  = '{5'd6,  5'd8,  1'b1, 5'd6,  32'h00000055, 32'h0,        32'h0};
    vecs[10] = '{5'd6,  5'd5,  1'b0, 5'd0,  32'h0,        32'h00000055, 32'hDEADBEEF};

    rst_n           = 1'b0;
    rs1             = '0;
    rs2             = '0;
    rd              = '0;
    rd_write_enable = 1'b0;
    rd_data_in      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Every index reads zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rs1[%0d]", i), rs1_data_out, 32'h0);
      check($sformatf("rst_rs2[%0d]", 31 - i), rs2_data_out, 32'h0);
    end

    // Table: inputs applied mid-cycle, reads checked before the write edge.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      rs1             = vecs[v].rs1;
      rs2             = vecs[v].rs2;
      rd              = vecs[v].rd;
      rd_write_enable = vecs[v].we;
      rd_data_in      = vecs[v].data;
      #1;
      check($sformatf("vec%0d_rs1", v), rs1_data_out, vecs[v].exp1);
      check($sformatf("vec%0d_rs2", v), rs2_data_out, vecs[v].exp2);
      if (vecs[v].we && vecs[v].rd != 5'd0) mdl[vecs[v].rd] = vecs[v].data;
    end
    @(negedge clk);
    rd_write_enable = 1'b0;

    rs2 = 5'd31;
    #1;
    check("x31_is_neg", {31'h0, rs2_data_out < 0}, 32'h1);

    // Full sweep: only the written registers hold data.
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      check($sformatf("sweep_x%0d", i), rs1_data_out, mdl[i]);
    end

    // Data/index changes just after the edge must not alter the write.
    @(negedge clk);
    rd = 5'd9; rd_data_in = 32'h99; rd_write_enable = 1'b1;
    @(posedge clk);
    #1;
    rd = 5'd10; rd_data_in = 32'h1010; rd_write_enable = 1'b0;
    rs1 = 5'd9; rs2 = 5'd10;
    #1;
    check("hold_x9", rs1_data_out, 32'h99);
    check("hold_x10", rs2_data_out, 32'h0);

    // Asynchronous reset mid-cycle clears immediately; writes during reset are lost.
    @(negedge clk);
    rd = 5'd3; rd_data_in = 32'h55; rd_write_enable = 1'b1;
    @(negedge clk);
    rd_write_enable = 1'b0;
    rs1 = 5'd3;
    #1;
    check("x3_before_rst", rs1_data_out, 32'h55);
    #1;
    rst_n = 1'b0;
    #1;
    check("x3_async_clr", rs1_data_out, 32'h0);
    rs2 = 5'd5;
    #1;
    check("x5_async_clr", rs2_data_out, 32'h0);
    rd = 5'd3; rd_data_in = 32'h77; rd_write_enable = 1'b1;
    @(posedge clk);
    #1;
    check("x3_wr_in_rst", rs1_data_out, 32'h0);
    @(negedge clk);
    rd_write_enable = 1'b0;
    rst_n = 1'b1;
    #1;
    check("x3_after_rst", rs1_data_out, 32'h0);

    // First edge after reset release performs the write.
    rd = 5'd4; rd_data_in = 32'h44; rd_write_enable = 1'b1;
    rs1 = 5'd4;
    #1;
    check("x4_pre_edge", rs1_data_out, 32'h0);
    @(posedge clk);
    #1;
    rd_write_enable = 1'b0;
    #1;
    check("x4_first_edge", rs1_data_out, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
